// File: rtl/seg_scan4.sv
// Four-digit multiplexed scan driver for a downstream single-digit 7-segment decoder.
// Time-multiplexes a 16-bit word with dead time, leading-zero blanking and frame-synchronous updates.
module seg_scan4 #(
   parameter int unsigned DIV     = 50000,
   parameter int unsigned GAP_CYC = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] data,
   input  logic        load,
   input  logic        lz_en,
   output logic [3:0]  digit,
   output logic [3:0]  com,
   output logic        frame_done
);

   localparam int unsigned MAX_CNT = (DIV > GAP_CYC) ? DIV : GAP_CYC;
   localparam int unsigned CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
   localparam logic [CW-1:0] SHOW_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

   typedef enum logic {
      S_SHOW = 1'b0,
      S_GAP  = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   pending_q, pending_d;
   logic [15:0]   shadow_q, shadow_d;
   logic [3:0]    digit_q, digit_d;
   logic [3:0]    com_q, com_d;
   logic          frame_done_q, frame_done_d;

   logic          advance;
   logic          wrap;
   logic [15:0]   upper;
   logic          blank;

   // Sequencing: SHOW/GAP timing, digit index and the frame-boundary shadow update.
   always_comb begin
      pending_d = load ? data : pending_q;
      shadow_d  = shadow_q;
      idx_d     = idx_q;
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      advance   = 1'b0;
      wrap      = 1'b0;

      case (state_q)
         S_SHOW: begin
            if (cnt_q == SHOW_LAST) begin
               cnt_d = '0;
               if (GAP_CYC > 0) begin
                  state_d = S_GAP;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               advance = 1'b1;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = S_SHOW;
         end
      endcase

      if (advance) begin
         idx_d   = idx_q + 2'd1;
         state_d = S_SHOW;
         if (idx_q == 2'd3) begin
            // Shadow takes the pre-edge pending value; a coincident load lands next frame.
            shadow_d = pending_q;
            wrap     = 1'b1;
         end
      end
   end

   // Outputs are derived from next-state values so they line up with the state register.
   always_comb begin
      upper        = shadow_d >> {idx_d, 2'b00};
      blank        = lz_en && (idx_d != 2'd0) && (upper == 16'h0000);
      digit_d      = digit_q;
      com_d        = '0;
      frame_done_d = wrap;
      if (state_d == S_SHOW) begin
         digit_d = shadow_d[{idx_d, 2'b00} +: 4];
         if (!blank) begin
            com_d = 4'b0001 << idx_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_SHOW;
         cnt_q        <= '0;
         idx_q        <= '0;
         pending_q    <= '0;
         shadow_q     <= '0;
         digit_q      <= 4'h0;
         com_q        <= 4'b0001;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         pending_q    <= pending_d;
         shadow_q     <= shadow_d;
         digit_q      <= digit_d;
         com_q        <= com_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign digit      = digit_q;
   assign com        = com_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan4.sv
// Bench for seg_scan4: one instance with dead time, one without, both checked every
// cycle against a timeline model plus table-driven and hand-written corner sequences.
module tb_seg_scan4;

   localparam int unsigned DIV_A = 4;
   localparam int unsigned GAP_A = 2;
   localparam int unsigned DIV_B = 3;
   localparam int unsigned GAP_B = 0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load;
   logic        lz_en;
   logic [15:0] data;
   logic [3:0]  digit_a, com_a, digit_b, com_b;
   logic        fd_a, fd_b;

   seg_scan4 #(.DIV(DIV_A), .GAP_CYC(GAP_A)) u_a (
      .clk(clk), .rst_n(rst_n), .data(data), .load(load), .lz_en(lz_en),
      .digit(digit_a), .com(com_a), .frame_done(fd_a)
   );

   seg_scan4 #(.DIV(DIV_B), .GAP_CYC(GAP_B)) u_b (
      .clk(clk), .rst_n(rst_n), .data(data), .load(load), .lz_en(lz_en),
      .digit(digit_b), .com(com_b), .frame_done(fd_b)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   // Model state: clocks since reset release, per-instance shadow, shared pending word.
   int unsigned m_div[2] = '{DIV_A, DIV_B};
   int unsigned m_gap[2] = '{GAP_A, GAP_B};
   int unsigned m_t[2]   = '{0, 0};
   logic [15:0] m_shadow[2] = '{16'h0, 16'h0};
   logic [15:0] m_pend = 16'h0;
   logic        m_lz   = 1'b0;

   int          lit_cnt[4];
   logic [3:0]  dig1;

   typedef struct {
      int unsigned ncyc;
      logic        ld;
      logic [15:0] dv;
      logic [3:0]  com;
      logic [3:0]  dig;
      logic        fd;
   } row_t;

   row_t tbl[9];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic logic [8:0] model_out(input int i);
      int unsigned per, p, k, w;
      logic [15:0] upper;
      logic [3:0]  c;
      logic        blank, f;
      per   = m_div[i] + m_gap[i];
      p     = m_t[i] % (4 * per);
      k     = p / per;
      w     = p % per;
      upper = m_shadow[i] >> (4 * k);
      blank = m_lz && (k != 0) && (upper == 16'h0000);
      c     = (w < m_div[i] && !blank) ? 4'(1 << k) : 4'h0;
      f     = (m_t[i] != 0) && (p == 0);
      return {f, c, upper[3:0]};
   endfunction

   task automatic compare_all();
      logic [8:0] ea, eb;
      ea = model_out(0);
      eb = model_out(1);
      chk("a_com",   16'(com_a),   16'(ea[7:4]));
      chk("a_digit", 16'(digit_a), 16'(ea[3:0]));
      chk("a_fd",    16'(fd_a),    16'(ea[8]));
      chk("b_com",   16'(com_b),   16'(eb[7:4]));
      chk("b_digit", 16'(digit_b), 16'(eb[3:0]));
      chk("b_fd",    16'(fd_b),    16'(eb[8]));
   endtask

   task automatic model_reset();
      m_t[0] = 0; m_t[1] = 0;
      m_shadow[0] = 16'h0; m_shadow[1] = 16'h0;
      m_pend = 16'h0;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_t[i]++;
            if (m_t[i] % (4 * (m_div[i] + m_gap[i])) == 0) m_shadow[i] = m_pend;
         end
         m_lz = lz_en;
         if (load) m_pend = data;
      end
      @(negedge clk);
      compare_all();
   endtask

   task automatic run_to(input int unsigned target);
      while (m_t[0] < target) tick();
   endtask

   // One full frame of instance A starting at a frame boundary; optional load on its first edge.
   task automatic frame_lit(input logic ld, input logic [15:0] dv);
      for (int b = 0; b < 4; b++) lit_cnt[b] = 0;
      dig1 = 4'hx;
      for (int i = 0; i < 24; i++) begin
         for (int b = 0; b < 4; b++) if (com_a[b]) lit_cnt[b]++;
         if (com_a == 4'b0010) dig1 = digit_a;
         load = (i == 0) && ld;
         data = dv;
         tick();
         load = 1'b0;
      end
   endtask

   initial begin
      int n, zeros, onehot, pulses;

      tbl[0] = '{4, 1'b0, 16'h0000, 4'b0001, 4'h1, 1'b1};
      tbl[1] = '{2, 1'b0, 16'h0000, 4'b0000, 4'h1, 1'b0};
      tbl[2] = '{4, 1'b1, 16'h9999, 4'b0010, 4'h2, 1'b0};
      tbl[3] = '{2, 1'b0, 16'h0000, 4'b0000, 4'h2, 1'b0};
      tbl[4] = '{4, 1'b0, 16'h0000, 4'b0100, 4'h3, 1'b0};
      tbl[5] = '{2, 1'b0, 16'h0000, 4'b0000, 4'h3, 1'b0};
      tbl[6] = '{4, 1'b0, 16'h0000, 4'b1000, 4'h4, 1'b0};
      tbl[7] = '{2, 1'b0, 16'h0000, 4'b0000, 4'h4, 1'b0};
      tbl[8] = '{4, 1'b0, 16'h0000, 4'b0001, 4'h9, 1'b1};

      rst_n = 1'b1; load = 1'b0; data = 16'h0; lz_en = 1'b0;
      #1 rst_n = 1'b0;
      #11;
      chk("rst_com_a",   16'(com_a),   16'h0001);
      chk("rst_digit_a", 16'(digit_a), 16'h0000);
      chk("rst_fd_a",    16'(fd_a),    16'h0000);
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Latch 4321 into pending, let one frame pass so it reaches the shadow.
      load = 1'b1; data = 16'h4321;
      tick();
      load = 1'b0;
      run_to(23);

      // Scan timing and tear-free update (9999 loaded while digit 1 is showing).
      for (int r = 0; r < 9; r++) begin
         for (int unsigned c = 0; c < tbl[r].ncyc; c++) begin
            load = (c == 0) && tbl[r].ld;
            data = tbl[r].dv;
            tick();
            load = 1'b0;
            chk("tbl_com",   16'(com_a),   16'(tbl[r].com));
            chk("tbl_digit", 16'(digit_a), 16'(tbl[r].dig));
            chk("tbl_fd",    16'(fd_a),    16'((c == 0) ? tbl[r].fd : 1'b0));
         end
      end

      // Load coinciding with frame_done: old pending shows for one more frame.
      run_to(60);
      load = 1'b1; data = 16'h1234;
      tick();
      load = 1'b0;
      run_to(72);
      chk("wrap_fd", 16'(fd_a), 16'h0001);
      load = 1'b1; data = 16'h5555;
      tick();
      load = 1'b0;
      chk("wrap_old_d0", 16'(digit_a), 16'h0004);
      run_to(84);
      chk("wrap_old_d2", 16'(digit_a), 16'h0002);
      run_to(96);
      chk("wrap_new_d0", 16'(digit_a), 16'h0005);

      // Leading-zero blanking.
      lz_en = 1'b1;
      load = 1'b1; data = 16'h0070;
      tick();
      load = 1'b0;
      run_to(120);
      frame_lit(1'b1, 16'h0000);
      chk_int("lz70_lit0", lit_cnt[0], 4);
      chk_int("lz70_lit1", lit_cnt[1], 4);
      chk_int("lz70_lit2", lit_cnt[2], 0);
      chk_int("lz70_lit3", lit_cnt[3], 0);
      chk("lz70_dig1", 16'(dig1), 16'h0007);
      frame_lit(1'b0, 16'h0000);
      chk_int("lz00_lit0", lit_cnt[0], 4);
      chk_int("lz00_lit1", lit_cnt[1], 0);
      chk_int("lz00_lit3", lit_cnt[3], 0);
      lz_en = 1'b0;
      frame_lit(1'b0, 16'h0000);
      chk_int("nolz_lit0", lit_cnt[0], 4);
      chk_int("nolz_lit1", lit_cnt[1], 4);
      chk_int("nolz_lit2", lit_cnt[2], 4);
      chk_int("nolz_lit3", lit_cnt[3], 4);

      // No dead time: instance B is always lit with one digit, frame every 12 clocks.
      zeros = 0; onehot = 0; pulses = 0;
      for (int i = 0; i < 24; i++) begin
         tick();
         if (com_b == 4'b0000) zeros++;
         if ($onehot(com_b)) onehot++;
         if (fd_b) pulses++;
      end
      chk_int("b_zero_cycles", zeros, 0);
      chk_int("b_onehot_cycles", onehot, 24);
      chk_int("b_frame_pulses", pulses, 2);

      // Randomized traffic with frequent leading zeros.
      for (int i = 0; i < 600; i++) begin
         load  = ($urandom_range(0, 3) == 0);
         data  = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4)));
         lz_en = 1'($urandom_range(0, 1));
         tick();
         load = 1'b0;
      end

      // Asynchronous reset in the middle of a GAP phase.
      n = 0;
      while (((m_t[0] % 24) % 6) < 4 && n < 30) begin
         tick();
         n++;
      end
      chk_int("gap_reached", ((m_t[0] % 24) % 6) >= 4 ? 1 : 0, 1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst_com_a",   16'(com_a),   16'h0001);
      chk("arst_digit_a", 16'(digit_a), 16'h0000);
      chk("arst_fd_a",    16'(fd_a),    16'h0000);
      chk("arst_com_b",   16'(com_b),   16'h0001);
      lz_en = 1'b0;
      tick();
      rst_n = 1'b1;
      n = 0;
      while (com_a == 4'b0001 && n < 20) begin
         tick();
         n++;
      end
      chk_int("first_advance", n, int'(DIV_A));
      for (int i = 0; i < 30; i++) tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
